// File: rtl/imu_seq_pkg.sv
// Shared types and command tables for the IMU SPI transaction sequencer.
// Command words are {R/W, addr[6:0], data[7:0]}.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT_SND = 3'd1,
    INIT_WT  = 3'd2,
    IDLE     = 3'd3,
    RD_SND   = 3'd4,
    RD_WT    = 3'd5,
    UPDATE   = 3'd6
  } state_t;

  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] INIT_LAST = 2'd2;
  localparam logic [IDX_W-1:0] RD_LAST   = 2'd3;

  localparam logic [15:0] INIT_CMD [0:2] = '{16'h0D02, 16'h1160, 16'h1440};

  // Read order: pitch lo, pitch hi, yaw lo, yaw hi.
  localparam logic [15:0] RD_CMD [0:3] = '{16'hA200, 16'hA300, 16'hA600, 16'hA700};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/imu_spi_seq.sv
// Sequencer driving the SPI monarch: power-up delay, three config writes,
// then a four-register read burst per data-ready, assembled into rate words.
module imu_spi_seq
  import imu_seq_pkg::*;
#(
  parameter logic [16:0] INIT_DLY = 17'h1FFFF,
  parameter logic [15:0] TMO_CYC  = 16'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        err
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [16:0]      pwr_cnt_q, pwr_cnt_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       byte_q [0:3];
  logic [7:0]       byte_d [0:3];
  logic             snd_q, snd_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      ptch_q, ptch_d;
  logic [15:0]      yaw_q, yaw_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             int_s;
  logic             unused_resp_hi;

  assign unused_resp_hi = ^resp[15:8];

  sync_2ff u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pwr_cnt_d = pwr_cnt_q;
    tmo_d     = tmo_q;
    byte_d    = byte_q;
    snd_d     = 1'b0;
    cmd_d     = cmd_q;
    ptch_d    = ptch_q;
    yaw_d     = yaw_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        idx_d = '0;
        if (pwr_cnt_q == INIT_DLY) begin
          state_d = INIT_SND;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 17'd1;
        end
      end
      INIT_SND: begin
        tmo_d   = '0;
        state_d = INIT_WT;
      end
      INIT_WT: begin
        tmo_d = tmo_q + 16'd1;
        if (done) begin
          if (idx_q == INIT_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = INIT_SND;
          end
        end else if (tmo_q == TMO_CYC) begin
          // A lost config write is retried; the sensor is useless without it.
          err_d   = 1'b1;
          state_d = INIT_SND;
        end
      end
      IDLE: begin
        if (int_s) begin
          idx_d   = '0;
          state_d = RD_SND;
        end
      end
      RD_SND: begin
        tmo_d   = '0;
        state_d = RD_WT;
      end
      RD_WT: begin
        tmo_d = tmo_q + 16'd1;
        if (done) begin
          byte_d[idx_q] = resp[7:0];
          if (idx_q == RD_LAST) begin
            state_d = UPDATE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD_SND;
          end
        end else if (tmo_q == TMO_CYC) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = PWR_WAIT;
      end
    endcase

    // Registered outputs are loaded on entry so they line up with the new state.
    if (state_d == INIT_SND) begin
      snd_d = 1'b1;
      cmd_d = INIT_CMD[idx_d];
    end else if (state_d == RD_SND) begin
      snd_d = 1'b1;
      cmd_d = RD_CMD[idx_d];
    end

    if (state_d == UPDATE) begin
      vld_d  = 1'b1;
      ptch_d = {byte_d[1], byte_d[0]};
      yaw_d  = {byte_d[3], byte_d[2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PWR_WAIT;
      idx_q     <= '0;
      pwr_cnt_q <= '0;
      tmo_q     <= '0;
      snd_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      ptch_q    <= 16'h0000;
      yaw_q     <= 16'h0000;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        byte_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pwr_cnt_q <= pwr_cnt_d;
      tmo_q     <= tmo_d;
      snd_q     <= snd_d;
      cmd_q     <= cmd_d;
      ptch_q    <= ptch_d;
      yaw_q     <= yaw_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) begin
        byte_q[i] <= byte_d[i];
      end
    end
  end

  assign snd     = snd_q;
  assign cmd     = cmd_q;
  assign ptch_rt = ptch_q;
  assign yaw_rt  = yaw_q;
  assign vld     = vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_imu_spi_seq.sv
// Directed bench for imu_spi_seq with a behavioural SPI monarch answering each snd.
module tb_imu_spi_seq;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] resp;
  logic        snd;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        err;

  logic        model_done;
  logic [15:0] model_resp;
  logic        inj_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          snd_n = 0;
  logic [15:0] snd_cmd [0:255];
  int          snd_cyc [0:255];
  int          done_n = 0;
  int          done_cyc = 0;
  int          vld_n = 0;
  int          err_n = 0;
  int          withhold_n = -1;
  int          done_dly = 40;
  logic [7:0]  rb [0:3];

  assign done = model_done | inj_done;
  assign resp = model_resp;

  imu_spi_seq #(
    .INIT_DLY (17'd16),
    .TMO_CYC  (16'd64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .resp    (resp),
    .snd     (snd),
    .cmd     (cmd),
    .ptch_rt (ptch_rt),
    .yaw_rt  (yaw_rt),
    .vld     (vld),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cyc %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [7:0] byte_for(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   byte_for = rb[0];
      8'hA3:   byte_for = rb[1];
      8'hA6:   byte_for = rb[2];
      8'hA7:   byte_for = rb[3];
      default: byte_for = 8'h00;
    endcase
  endfunction

  // SPI monarch model plus pulse monitors, sampled 1 time unit after each edge.
  initial begin : model
    int          wait_cnt;
    logic [15:0] out_cmd;
    wait_cnt   = 0;
    out_cmd    = '0;
    model_done = 1'b0;
    model_resp = 16'h0000;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (vld) vld_n++;
      if (err) err_n++;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (snd) begin
        snd_cmd[snd_n & 255] = cmd;
        snd_cyc[snd_n & 255] = cyc;
        snd_n++;
        out_cmd  = cmd;
        wait_cnt = (withhold_n == snd_n) ? 0 : done_dly;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          chk("cmd_stable", {16'h0, cmd}, {16'h0, out_cmd});
          model_done = 1'b1;
          model_resp = {8'hEE, byte_for(out_cmd)};
          done_n++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_inj();
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
  endtask

  task automatic wait_snds(input int n);
    int k;
    k = 0;
    while (snd_n < n && k < 3000) begin
      step();
      k++;
    end
    if (snd_n < n) chk("snd_timeout", snd_n, n);
  endtask

  task automatic wait_vld(output int at);
    int k;
    k = 0;
    at = -1;
    while (!vld && k < 3000) begin
      step();
      k++;
    end
    if (vld) at = cyc;
    else chk("vld_timeout", {31'b0, vld}, 1);
  endtask

  task automatic wait_dones(input int n);
    int k;
    k = 0;
    while (done_n < n && k < 3000) begin
      step();
      k++;
    end
    if (done_n < n) chk("done_timeout", done_n, n);
  endtask

  task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
  endtask

  task automatic chk_rd_cmds(input int b);
    chk("rd_cmd0", {16'h0, snd_cmd[b]},   32'hA200);
    chk("rd_cmd1", {16'h0, snd_cmd[b+1]}, 32'hA300);
    chk("rd_cmd2", {16'h0, snd_cmd[b+2]}, 32'hA600);
    chk("rd_cmd3", {16'h0, snd_cmd[b+3]}, 32'hA700);
  endtask

  initial begin : main
    int rst_cyc, int_cyc, b, v0, e0, vat, vat1, eat, k;
    rst_n    = 1'b0;
    INT      = 1'b0;
    inj_done = 1'b0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) step();

    chk("rst_snd",  {31'b0, snd}, 0);
    chk("rst_cmd",  {16'h0, cmd}, 0);
    chk("rst_ptch", {16'h0, ptch_rt}, 0);
    chk("rst_yaw",  {16'h0, yaw_rt}, 0);
    chk("rst_vld",  {31'b0, vld}, 0);
    chk("rst_err",  {31'b0, err}, 0);

    // 1+5: init sequence, with a stray done during the power-up wait
    rst_n   = 1'b1;
    rst_cyc = cyc;
    repeat (5) step();
    pulse_inj();
    wait_snds(3);
    chk("init_lat",  snd_cyc[0] - rst_cyc, 17);
    chk("init_cmd0", {16'h0, snd_cmd[0]}, 32'h0D02);
    chk("init_cmd1", {16'h0, snd_cmd[1]}, 32'h1160);
    chk("init_cmd2", {16'h0, snd_cmd[2]}, 32'h1440);
    repeat (50) step();
    chk("init_only", snd_n, 3);

    // 2: single read burst
    set_bytes(8'h34, 8'h12, 8'h78, 8'h56);
    b = snd_n; v0 = vld_n;
    INT = 1'b1; int_cyc = cyc;
    wait_snds(b + 1);
    INT = 1'b0;
    wait_vld(vat);
    chk("int_lat", snd_cyc[b] - int_cyc, 3);
    chk_rd_cmds(b);
    chk("ptch1", {16'h0, ptch_rt}, 32'h1234);
    chk("yaw1",  {16'h0, yaw_rt},  32'h5678);
    chk("vld_lat", vat - done_cyc, 1);
    step();
    chk("vld_width", {31'b0, vld}, 0);
    repeat (10) step();
    chk("vld_cnt1", vld_n - v0, 1);

    // 3: INT held across two bursts
    set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    b = snd_n; v0 = vld_n;
    INT = 1'b1;
    wait_vld(vat1);
    chk("ptch2a", {16'h0, ptch_rt}, 32'h2211);
    chk("yaw2a",  {16'h0, yaw_rt},  32'h4433);
    set_bytes(8'h55, 8'h66, 8'h77, 8'h88);
    wait_snds(b + 5);
    INT = 1'b0;
    chk("burst_gap", snd_cyc[b+4] - vat1, 2);
    step();
    wait_vld(vat);
    chk("ptch2b", {16'h0, ptch_rt}, 32'h6655);
    chk("yaw2b",  {16'h0, yaw_rt},  32'h8877);
    chk_rd_cmds(b + 4);
    repeat (10) step();
    chk("vld_cnt2", vld_n - v0, 2);
    chk("snd_cnt2", snd_n - b, 8);

    // 4: third read never answered
    set_bytes(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    b = snd_n; v0 = vld_n; e0 = err_n;
    withhold_n = b + 3;
    INT = 1'b1;
    wait_snds(b + 1);
    INT = 1'b0;
    k = 0;
    eat = -1;
    while (!err && k < 400) begin
      step();
      k++;
    end
    if (err) eat = cyc;
    chk("err_seen", {31'b0, err}, 1);
    chk("tmo_window", {31'b0, ((eat - snd_cyc[b+2]) >= 64) && ((eat - snd_cyc[b+2]) <= 67)}, 1);
    repeat (20) step();
    chk("err_cnt", err_n - e0, 1);
    chk("tmo_no_vld", vld_n - v0, 0);
    chk("tmo_ptch", {16'h0, ptch_rt}, 32'h6655);
    chk("tmo_yaw",  {16'h0, yaw_rt},  32'h8877);
    chk("tmo_no_retry", snd_n - b, 3);
    withhold_n = -1;
    b = snd_n;
    INT = 1'b1; int_cyc = cyc;
    wait_snds(b + 1);
    INT = 1'b0;
    chk("idle_after_tmo", snd_cyc[b] - int_cyc, 3);
    wait_vld(vat);
    chk("ptch3", {16'h0, ptch_rt}, 32'hBC9A);
    chk("yaw3",  {16'h0, yaw_rt},  32'hF0DE);
    repeat (5) step();

    // 5: stray done while idle
    b = snd_n; v0 = vld_n;
    pulse_inj();
    repeat (20) step();
    chk("spur_no_snd",  snd_n - b, 0);
    chk("spur_no_vld",  vld_n - v0, 0);
    chk("spur_ptch", {16'h0, ptch_rt}, 32'hBC9A);
    set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    INT = 1'b1; int_cyc = cyc;
    wait_snds(b + 1);
    INT = 1'b0;
    chk("spur_int_lat", snd_cyc[b] - int_cyc, 3);
    wait_vld(vat);
    chk("ptch4", {16'h0, ptch_rt}, 32'h0201);
    chk("yaw4",  {16'h0, yaw_rt},  32'h0403);
    repeat (5) step();

    // 6: reset in the middle of a read burst
    set_bytes(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    b = snd_n;
    INT = 1'b1;
    wait_snds(b + 1);
    INT = 1'b0;
    wait_dones(done_n + 2);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_snd",  {31'b0, snd}, 0);
    chk("mid_rst_cmd",  {16'h0, cmd}, 0);
    chk("mid_rst_ptch", {16'h0, ptch_rt}, 0);
    chk("mid_rst_yaw",  {16'h0, yaw_rt}, 0);
    chk("mid_rst_vld",  {31'b0, vld}, 0);
    chk("mid_rst_err",  {31'b0, err}, 0);
    repeat (2) step();
    rst_n   = 1'b1;
    rst_cyc = cyc;
    b = snd_n;
    wait_snds(b + 3);
    chk("reinit_lat",  snd_cyc[b] - rst_cyc, 17);
    chk("reinit_cmd0", {16'h0, snd_cmd[b]},   32'h0D02);
    chk("reinit_cmd1", {16'h0, snd_cmd[b+1]}, 32'h1160);
    chk("reinit_cmd2", {16'h0, snd_cmd[b+2]}, 32'h1440);
    repeat (50) step();
    chk("reinit_only", snd_n - b, 3);
    chk("reinit_ptch", {16'h0, ptch_rt}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
